// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and the data-length clamp helper.
package uart_pkg;
    localparam int UART_MIN_DATA_BITS = 5;
    localparam int DATA_LEN_W = 4;
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_mode_e;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        , ST_BREAK
`endif
    } tx_state_e;
    function automatic logic [DATA_LEN_W-1:0] clamp_len(input logic [DATA_LEN_W-1:0] len, input int max_bits);
        return len < DATA_LEN_W'(UART_MIN_DATA_BITS) ? DATA_LEN_W'(UART_MIN_DATA_BITS) :
               len > DATA_LEN_W'(max_bits) ? DATA_LEN_W'(max_bits) : len;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts oversample ticks and flags the tick that ends a bit time.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart_i,
    input  logic tick_i,
    output logic bit_end_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    logic [CW-1:0] cnt;
    assign bit_end_o = tick_i && cnt == CW'(OVERSAMPLE - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (restart_i) cnt <= '0;
        else if (tick_i) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter with runtime data length, parity and stop bits.
// Define UART_TX_BREAK_EN to add the break_i input and line-break generation.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tx_en_i,
    input  logic                     tick_i,
    input  logic [DATA_LEN_W-1:0]    cfg_data_bits_i,
    input  logic [1:0]               cfg_parity_i,
    input  logic                     cfg_stop2_i,
    input  logic [MAX_DATA_BITS-1:0] tx_data_i,
    input  logic                     tx_valid_i,
`ifdef UART_TX_BREAK_EN
    input  logic                     break_i,
`endif
    output logic                     tx_ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int CW = DATA_LEN_W + 1;
    tx_state_e state, state_n;
    parity_mode_e par_mode, par_mode_n;
    logic [MAX_DATA_BITS-1:0] sh, sh_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [DATA_LEN_W-1:0] len, len_n;
    logic stop2, stop2_n, stop_cnt, stop_cnt_n, par_acc, par_acc_n, tx_n, done_n;
    logic bit_end, restart;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .restart_i(restart),
        .tick_i(tick_i),
        .bit_end_o(bit_end)
    );

`ifdef UART_TX_BREAK_EN
    logic [CW-1:0] brk_bits;
    logic brk_min;
    assign brk_bits = CW'(2) + CW'(clamp_len(cfg_data_bits_i, MAX_DATA_BITS)) +
                      CW'(cfg_parity_i != PAR_NONE) + CW'(cfg_stop2_i);
    assign brk_min = bit_cnt + CW'(bit_end) >= brk_bits;
    assign tx_ready_o = reset_n && tx_en_i && state == ST_IDLE && !break_i;
    assign busy_o = state != ST_IDLE && state != ST_BREAK;
`else
    assign tx_ready_o = reset_n && tx_en_i && state == ST_IDLE;
    assign busy_o = state != ST_IDLE;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            par_mode <= PAR_NONE;
            sh       <= '0;
            bit_cnt  <= '0;
            len      <= '0;
            stop2    <= 1'b0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            tx_o     <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            state    <= state_n;
            par_mode <= par_mode_n;
            sh       <= sh_n;
            bit_cnt  <= bit_cnt_n;
            len      <= len_n;
            stop2    <= stop2_n;
            stop_cnt <= stop_cnt_n;
            par_acc  <= par_acc_n;
            tx_o     <= tx_n;
            done_o   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        par_mode_n = par_mode;
        sh_n       = sh;
        bit_cnt_n  = bit_cnt;
        len_n      = len;
        stop2_n    = stop2;
        stop_cnt_n = stop_cnt;
        par_acc_n  = par_acc;
        tx_n       = tx_o;
        done_n     = 1'b0;
        restart    = state == ST_IDLE || bit_end;
        case (state)
            ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (tx_en_i && break_i) begin
                    state_n    = ST_BREAK;
                    tx_n       = 1'b0;
                    bit_cnt_n  = '0;
                    stop_cnt_n = 1'b0;
                end else
`endif
                if (tx_valid_i && tx_ready_o) begin
                    state_n    = ST_START;
                    sh_n       = tx_data_i;
                    len_n      = clamp_len(cfg_data_bits_i, MAX_DATA_BITS);
                    par_mode_n = parity_mode_e'(cfg_parity_i);
                    stop2_n    = cfg_stop2_i;
                    par_acc_n  = 1'b0;
                    tx_n       = 1'b0;
                end
            end
            ST_START: if (bit_end) begin
                state_n   = ST_DATA;
                bit_cnt_n = '0;
                tx_n      = sh[0];
            end
            ST_DATA: if (bit_end) begin
                par_acc_n = par_acc ^ sh[0];
                if (bit_cnt == CW'(len) - 1'b1) begin
                    state_n    = par_mode == PAR_NONE ? ST_STOP : ST_PARITY;
                    stop_cnt_n = 1'b0;
                    tx_n       = (par_mode == PAR_EVEN || par_mode == PAR_ODD) ?
                                 (par_acc ^ sh[0] ^ (par_mode == PAR_ODD)) : 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    sh_n      = sh >> 1;
                    tx_n      = sh[1];
                end
            end
            ST_PARITY: if (bit_end) begin
                state_n = ST_STOP;
                tx_n    = 1'b1;
            end
            ST_STOP: if (bit_end) begin
                if (stop2 && !stop_cnt) stop_cnt_n = 1'b1;
                else begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            // stop_cnt marks the trailing high bit; its timer restarts on release
            ST_BREAK: begin
                if (stop_cnt) begin
                    if (bit_end) state_n = ST_IDLE;
                end else if (brk_min && !break_i) begin
                    stop_cnt_n = 1'b1;
                    tx_n       = 1'b1;
                    restart    = 1'b1;
                end else if (bit_end && bit_cnt < brk_bits) bit_cnt_n = bit_cnt + 1'b1;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end
endmodule
